// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction-fetch front end.
//
// Owns the fetch PC, issues at most one outstanding request on the
// instruction bus, and queues returned instructions (with their PCs) in a
// DEPTH-entry FIFO that decode drains. A redirect flushes the FIFO and
// retargets fetch. If a request is still in flight, its response is
// discarded in the DRAIN state.
//
// Handshakes:
//   - Instruction bus: ireq_valid/ireq_addr are registered. Once raised,
//     they hold until the cycle iresp_data_ok=1. No request is issued in
//     that same cycle.
//   - Decode: the FIFO head is consumed when instr_valid & instr_ready.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   ireq_valid/addr  bus request (out)
//   iresp_data_ok    bus response strobe and iresp_data (in)
//   redirect_valid   redirect strobe and redirect_pc (in)
//   instr_valid      FIFO head valid, with instr_pc and instr_data (out)
//   instr_ready      decode accepts the head (in)
//   count            registered FIFO occupancy (out)
module fetch_buffer #(
  parameter int XLEN = 64,
  parameter int ILEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       ireq_valid,
  output logic [XLEN-1:0]            ireq_addr,
  input  logic                       iresp_data_ok,
  input  logic [ILEN-1:0]            iresp_data,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       instr_valid,
  output logic [XLEN-1:0]            instr_pc,
  output logic [ILEN-1:0]            instr_data,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            req_valid_q;
  logic [XLEN-1:0] req_addr_q;
  logic [CW-1:0]   cnt_q, count_next;
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic            enq, deq;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [ILEN-1:0] data_mem [DEPTH];

  // A redirect wins over everything, so it suppresses both the dequeue and
  // the enqueue of a response arriving in the same cycle.
  assign deq = (cnt_q != '0) && instr_ready && !redirect_valid;
  assign enq = (state_q == S_REQ) && iresp_data_ok && !redirect_valid;
  // A request is issued only while a slot is free for its response, so
  // this sum never exceeds DEPTH.
  assign count_next = cnt_q + CW'(enq) - CW'(deq);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    unique case (state_q)
      S_IDLE: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc;
          state_d    = S_REQ;
        end else if (count_next < CW'(DEPTH)) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc;
          // A response in the redirect cycle is simply dropped. Without
          // one, the old request is still on the bus and must be drained.
          state_d = iresp_data_ok ? S_IDLE : S_DRAIN;
        end else if (iresp_data_ok) begin
          fetch_pc_d = fetch_pc_q + XLEN'(4);
          state_d    = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (redirect_valid) fetch_pc_d = redirect_pc;
        if (iresp_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      req_valid_q <= 1'b0;
      req_addr_q  <= RESET_PC;
      cnt_q       <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_valid_q <= (state_d != S_IDLE);
      // The address is captured only when leaving IDLE. It then holds
      // through REQ and DRAIN, even after fetch_pc moves to a redirect
      // target.
      if (state_q == S_IDLE) req_addr_q <= fetch_pc_d;
      if (redirect_valid) begin
        cnt_q    <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        cnt_q <= count_next;
        if (enq) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (deq) rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
      data_mem[wr_ptr_q] <= iresp_data;
    end
  end

  assign ireq_valid  = req_valid_q;
  assign ireq_addr   = req_addr_q;
  assign instr_valid = (cnt_q != '0);
  assign instr_pc    = pc_mem[rd_ptr_q];
  assign instr_data  = data_mem[rd_ptr_q];
  assign count       = cnt_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed scenarios plus a randomized phase for
// fetch_buffer.
//
// The reference model tracks the fetch front end abstractly:
//   - the expected FIFO contents, as a queue;
//   - whether a request is outstanding, and its address;
//   - whether that request's response is to be dropped;
//   - the next fetch PC.
// A bus responder answers each request after a chosen latency. Outputs are
// checked at every negedge.
module tb_fetch_buffer;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;

  logic            clk = 1'b0;
  logic            reset;
  logic            ireq_valid;
  logic [XLEN-1:0] ireq_addr;
  logic            iresp_data_ok;
  logic [ILEN-1:0] iresp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_valid;
  logic [XLEN-1:0] instr_pc;
  logic [ILEN-1:0] instr_data;
  logic            instr_ready;
  logic [CW-1:0]   count;

  always #5 clk = ~clk;

  fetch_buffer #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_pc(instr_pc), .instr_data(instr_data),
    .instr_ready(instr_ready), .count(count)
  );

  int checks = 0;
  int errors = 0;

  // Expected FIFO contents: {pc, instruction}.
  logic [XLEN+ILEN-1:0] exp_q[$];
  // Request addresses observed on the DUT bus (rising ireq_valid).
  logic [XLEN-1:0]      dut_iss_q[$];
  logic                 prev_ireq_valid;

  // Model state.
  bit              m_pend;
  bit              m_drop;
  logic [XLEN-1:0] m_addr;
  logic [XLEN-1:0] m_fetch;

  // Stimulus knobs.
  // ready_mode: 0 = random, 1 = always ready, 2 = never ready,
  //             3 = ready only when a response is about to enqueue.
  int        lat_left;
  int        lat_mode;
  int        ready_mode;
  bit        stray_en;
  bit        force_en;
  logic [31:0] force_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    if (!prev_ireq_valid && ireq_valid) dut_iss_q.push_back(ireq_addr);
    prev_ireq_valid = ireq_valid;
    check("ireq_valid", ireq_valid, m_pend);
    if (m_pend) check("ireq_addr", ireq_addr, m_addr);
    check("count", count, exp_q.size());
    check("instr_valid", instr_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("instr_pc", instr_pc, exp_q[0][XLEN+ILEN-1:ILEN]);
      check("instr_data", instr_data, exp_q[0][ILEN-1:0]);
    end
  endtask

  // Apply this cycle's inputs to the abstract model (what the next cycle
  // looks like).
  task automatic model_update();
    bit was_pend = m_pend;
    bit redir = redirect_valid;
    if (exp_q.size() != 0 && instr_ready && !redir) void'(exp_q.pop_front());
    if (m_pend && iresp_data_ok) begin
      if (!m_drop && !redir) begin
        exp_q.push_back({m_addr, iresp_data});
        m_fetch = m_addr + 64'd4;
      end
      m_pend = 0;
      m_drop = 0;
    end else if (m_pend && redir) begin
      m_drop = 1;
    end
    if (redir) begin
      exp_q.delete();
      m_fetch = redirect_pc;
    end
    // A request goes out only from an idle cycle, and only if its response
    // has room (or a redirect has just emptied the FIFO).
    if (!was_pend && (redir || exp_q.size() < DEPTH)) begin
      m_pend   = 1;
      m_addr   = m_fetch;
      lat_left = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
    end
  endtask

  // One clock: check, drive inputs, update model, advance to next negedge.
  task automatic step();
    check_outputs();
    case (ready_mode)
      0: instr_ready = ($urandom_range(0, 2) != 0);
      1: instr_ready = 1'b1;
      2: instr_ready = 1'b0;
      default: instr_ready = m_pend && (lat_left == 0);
    endcase
    if (m_pend) begin
      if (lat_left == 0) begin
        iresp_data_ok = 1'b1;
      end else begin
        iresp_data_ok = 1'b0;
        lat_left--;
      end
    end else begin
      iresp_data_ok = stray_en && ($urandom_range(0, 7) == 0);
    end
    iresp_data = force_en ? force_data : $urandom();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    iresp_data_ok  = 1'b0;
    iresp_data     = '0;
    instr_ready    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    dut_iss_q.delete();
    prev_ireq_valid = 1'b0;
    m_pend  = 0;
    m_drop  = 0;
    m_addr  = RESET_PC;
    m_fetch = RESET_PC;
  endtask

  initial begin
    lat_mode   = 0;
    ready_mode = 2;
    stray_en   = 0;
    force_en   = 0;
    force_data = 32'hDEAD_BEEF;
    lat_left   = 0;
    do_reset();

    // Reset state.
    check("rst_ireq_valid", ireq_valid, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_count", count, 0);

    // Sequential fetch, two-cycle latency, decode always ready.
    ready_mode = 1;
    lat_mode   = 2;
    repeat (30) step();
    check("a_nreq", dut_iss_q.size() >= 3, 1);
    for (int k = 0; k < 3; k++)
      if (k < dut_iss_q.size()) check("a_addr", dut_iss_q[k], RESET_PC + 64'(4 * k));

    // Back-pressure: fills to DEPTH and stops, then one dequeue frees a slot.
    do_reset();
    ready_mode = 2;
    lat_mode   = 0;
    repeat (20) step();
    check("b_count_full", count, DEPTH);
    check("b_stalled", ireq_valid, 0);
    check("b_nreq", dut_iss_q.size(), DEPTH);
    ready_mode = 1;
    step();
    ready_mode = 2;
    check("b_count_after", count, DEPTH - 1);
    check("b_new_req", ireq_valid, 1);
    check("b_new_addr", ireq_addr, 64'h8000_0010);
    repeat (4) step();

    // Redirect while a request to 0x8000_0008 is in flight; drain it.
    do_reset();
    ready_mode = 1;
    lat_mode   = 1;
    for (int i = 0; i < 50 && !(m_pend && m_addr == 64'h8000_0008); i++) step();
    check("c_reach", m_pend && m_addr == 64'h8000_0008, 1);
    lat_left       = 3;
    force_en       = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1000;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 10 && m_pend; i++) begin
      check("c_hold", ireq_addr, 64'h8000_0008);
      check("c_nodead", instr_valid && instr_data == 32'hDEAD_BEEF, 0);
      step();
    end
    force_en = 0;
    check("c_nodead_idle", instr_valid && instr_data == 32'hDEAD_BEEF, 0);
    step();
    check("c_next_valid", ireq_valid, 1);
    check("c_next_addr", ireq_addr, 64'h8000_1000);
    repeat (6) step();

    // Redirect coinciding with data_ok while two entries are buffered.
    do_reset();
    ready_mode = 2;
    lat_mode   = 0;
    for (int i = 0; i < 50 && !(m_pend && exp_q.size() == 2); i++) step();
    check("d_reach", m_pend && exp_q.size() == 2, 1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_2000;
    step();
    redirect_valid = 1'b0;
    check("d_count", count, 0);
    check("d_instr_valid", instr_valid, 0);
    check("d_gap", ireq_valid, 0);
    step();
    check("d_next_valid", ireq_valid, 1);
    check("d_next_addr", ireq_addr, 64'h8000_2000);
    repeat (4) step();

    // Two redirects during DRAIN: the newest target wins.
    do_reset();
    ready_mode = 1;
    lat_mode   = 0;
    for (int i = 0; i < 10 && !m_pend; i++) step();
    lat_left       = 6;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h100;
    step();
    redirect_pc    = 64'h200;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 20 && m_pend; i++) step();
    check("e_drained", m_pend, 0);
    step();
    check("e_next_valid", ireq_valid, 1);
    check("e_next_addr", ireq_addr, 64'h200);
    repeat (4) step();

    // Steady enqueue+dequeue at occupancy 2 across pointer wrap.
    do_reset();
    ready_mode = 2;
    lat_mode   = 0;
    for (int i = 0; i < 50 && exp_q.size() != 2; i++) step();
    ready_mode = 3;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      check("f_count", count, 2);
      step();
    end

    // Randomized traffic: latencies, back-pressure, redirects, stray
    // responses, and resets in the middle of transactions.
    do_reset();
    ready_mode = 0;
    lat_mode   = -1;
    stray_en   = 1;
    for (int i = 0; i < 2000; i++) begin
      if (i % 500 == 250) do_reset();
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8
                                                : {$urandom(), $urandom()};
      step();
    end
    redirect_valid = 1'b0;
    stray_en = 0;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
